// File: rtl/conv_ctrl_pkg.sv
// Shared state encoding, default geometry and counter widths for the conv feed controller.
package conv_ctrl_pkg;
  localparam int DEF_IMG_WIDTH   = 512;
  localparam int DEF_IMG_HEIGHT  = 360;
  localparam int DEF_PRIME_LINES = 4;
  localparam int DEF_PAD_LINES   = 2;
  localparam int DEF_OUT_TOTAL   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

  localparam int LINE_CNT_W = 9;
  localparam int OUT_CNT_W  = 18;
  localparam int CREDIT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRIME, ST_WAIT_CREDIT, ST_LINE,
    ST_PAD_WAIT, ST_PAD, ST_DRAIN, ST_DONE
  } state_t;

  // Saturating up/down credit step; simultaneous inc and dec cancel out.
  function automatic logic [CREDIT_W-1:0] credit_next(input logic [CREDIT_W-1:0] c,
                                                      input logic inc, input logic dec);
    if (inc && !dec) return (c == '1) ? c : c + 1'b1;
    if (dec && !inc) return c - 1'b1;
    return c;
  endfunction
endpackage

// File: rtl/conv_feed_ctrl_if.sv
// Pixel stream bundle: upstream valid/data/ready in, conv-core valid/data out.
interface conv_feed_ctrl_if;
  logic       s_data_valid;
  logic [7:0] s_data;
  logic       s_data_ready;
  logic       m_data_valid;
  logic [7:0] m_data;

  modport master (input s_data_valid, s_data, output s_data_ready, m_data_valid, m_data);
  modport slave  (output s_data_valid, s_data, input s_data_ready, m_data_valid, m_data);
endinterface

// File: rtl/feed_line_cnt.sv
// Column and line counters for the feed; flags describe the line currently being sent.
module feed_line_cnt
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int PRIME_LINES = DEF_PRIME_LINES,
  parameter int PAD_LINES   = DEF_PAD_LINES
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  i_clr,
  input  logic                  i_adv,
  output logic                  o_last_pix,
  output logic                  o_prime_end,
  output logic                  o_last_img_line,
  output logic                  o_last_pad_line,
  output logic [LINE_CNT_W-1:0] o_line
);
  localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int LINE_MAX = IMG_HEIGHT + PAD_LINES;

  logic [COL_W-1:0]      r_col;
  logic [LINE_CNT_W-1:0] r_line;

  assign o_last_pix      = (r_col == COL_W'(IMG_WIDTH - 1));
  assign o_prime_end     = (r_line == LINE_CNT_W'(PRIME_LINES - 1));
  assign o_last_img_line = (r_line == LINE_CNT_W'(IMG_HEIGHT - 1));
  assign o_last_pad_line = (r_line == LINE_CNT_W'(LINE_MAX - 1));
  assign o_line          = r_line;

  // Line count holds at image+pad so it never wraps back to zero.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n || i_clr) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_adv) begin
      r_col <= o_last_pix ? '0 : r_col + 1'b1;
      if (o_last_pix && r_line != LINE_CNT_W'(LINE_MAX))
        r_line <= r_line + 1'b1;
    end
  end
endmodule

// File: rtl/conv_feed_ctrl.sv
// Feeds an image into the conv/maxpool core line by line, gated by line-buffer credits, then pads and drains.
module conv_feed_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int PRIME_LINES = DEF_PRIME_LINES,
  parameter int PAD_LINES   = DEF_PAD_LINES,
  parameter int OUT_TOTAL   = DEF_OUT_TOTAL
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   i_start,
  conv_feed_ctrl_if.master       bus,
  input  logic                   i_intr,
  input  logic                   i_out_valid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [LINE_CNT_W-1:0]  o_line_cnt
);
  state_t                r_state, w_next;
  logic                  r_intr_d;
  logic [CREDIT_W-1:0]   r_credit;
  logic [OUT_CNT_W-1:0]  r_out_cnt, w_out_nxt;
  logic w_fwd, w_pad, w_busy, w_start, w_adv, w_intr_rise, w_line_end, w_consume, w_out_beat;
  logic w_last_pix, w_prime_end, w_last_img_line, w_last_pad_line;

  assign w_fwd       = (r_state == ST_PRIME) || (r_state == ST_LINE);
  assign w_pad       = (r_state == ST_PAD);
  assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_start     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_adv       = (w_fwd && bus.s_data_valid) || w_pad;
  assign w_line_end  = w_adv && w_last_pix;
  assign w_intr_rise = i_intr && !r_intr_d;
  assign w_out_beat  = w_busy && i_out_valid;
  assign w_out_nxt   = r_out_cnt + OUT_CNT_W'(w_out_beat);

  feed_line_cnt #(
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
    .PRIME_LINES(PRIME_LINES), .PAD_LINES(PAD_LINES)
  ) u_cnt (
    .axi_clk         (axi_clk),
    .axi_reset_n     (axi_reset_n),
    .i_clr           (w_start),
    .i_adv           (w_adv),
    .o_last_pix      (w_last_pix),
    .o_prime_end     (w_prime_end),
    .o_last_img_line (w_last_img_line),
    .o_last_pad_line (w_last_pad_line),
    .o_line          (o_line_cnt)
  );

  always_comb begin
    w_next    = r_state;
    w_consume = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_next = ST_PRIME;
      ST_PRIME:         if (w_line_end && w_prime_end) w_next = ST_WAIT_CREDIT;
      ST_WAIT_CREDIT: if (r_credit != '0) begin
        w_consume = 1'b1;
        w_next    = ST_LINE;
      end
      ST_LINE:          if (w_line_end) w_next = w_last_img_line ? ST_PAD_WAIT : ST_WAIT_CREDIT;
      ST_PAD_WAIT: if (r_credit != '0) begin
        w_consume = 1'b1;
        w_next    = ST_PAD;
      end
      ST_PAD:           if (w_line_end) w_next = w_last_pad_line ? ST_DRAIN : ST_PAD_WAIT;
      // Count may already have reached the total during padding; leave on the next cycle then.
      ST_DRAIN:         if (w_out_nxt >= OUT_CNT_W'(OUT_TOTAL)) w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_state   <= ST_IDLE;
      r_intr_d  <= 1'b0;
      r_credit  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_intr_d <= i_intr;
      if (w_start) begin
        r_credit  <= '0;
        r_out_cnt <= '0;
      end else begin
        r_credit  <= credit_next(r_credit, w_intr_rise, w_consume);
        r_out_cnt <= w_out_nxt;
      end
    end
  end

  // Outputs are forced low while reset is held, not just after the first reset edge.
  assign bus.s_data_ready = axi_reset_n && w_fwd;
  assign bus.m_data_valid = axi_reset_n && ((w_fwd && bus.s_data_valid) || w_pad);
  assign bus.m_data       = (axi_reset_n && w_fwd) ? bus.s_data : '0;
  assign o_busy           = axi_reset_n && w_busy;
  assign o_done           = axi_reset_n && (r_state == ST_DONE);
endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Scoreboard bench: stimulus queues expected conv-core beats, a forked monitor pops them on m_data_valid.
module tb_conv_feed_ctrl;
  import conv_ctrl_pkg::*;

  localparam int W = 8, H = 6, PL = 4, PD = 2, OT = 48;

  logic       axi_clk = 1'b0;
  logic       axi_reset_n = 1'b0;
  logic       i_start = 1'b0, i_intr = 1'b0, i_out_valid = 1'b0;
  logic       o_busy, o_done;
  logic [8:0] o_line_cnt;

  conv_feed_ctrl_if bus();

  conv_feed_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PL), .PAD_LINES(PD), .OUT_TOTAL(OT)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .i_start     (i_start),
    .bus         (bus.master),
    .i_intr      (i_intr),
    .i_out_valid (i_out_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_line_cnt  (o_line_cnt)
  );

  always #5 axi_clk = ~axi_clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge axi_clk);
      if (bus.m_data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h with nothing expected", bus.m_data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 32'(bus.m_data), 32'(e));
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    sb.push_back(d);
    bus.s_data_valid = 1'b1;
    bus.s_data       = d;
    @(negedge axi_clk);
    while (bus.s_data_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge axi_clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ready stayed low for pixel %0h", d);
    end
    @(posedge axi_clk);
    #1;
    bus.s_data_valid = 1'b0;
  endtask

  task automatic send_line(input int l, input int from = 0, input int to = W - 1);
    for (int c = from; c <= to; c++) send(8'((l << 4) | c));
  endtask

  task automatic pulse_intr();
    i_intr = 1'b1;
    cyc(1);
    i_intr = 1'b0;
    cyc(1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      cyc(1);
    end
    chk("queue_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 20) begin
      n++;
      cyc(1);
    end
    chk("done_reached", 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    longint t0;
    bus.s_data_valid = 1'b0;
    bus.s_data       = '0;
    fork
      monitor();
    join_none

    // Reset state
    cyc(3);
    @(negedge axi_clk);
    chk("rst_m_valid", 32'(bus.m_data_valid), 32'd0);
    chk("rst_m_data",  32'(bus.m_data), 32'd0);
    chk("rst_ready",   32'(bus.s_data_ready), 32'd0);
    chk("rst_busy",    32'(o_busy), 32'd0);
    chk("rst_done",    32'(o_done), 32'd0);
    chk("rst_line",    32'(o_line_cnt), 32'd0);
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;
    cyc(1);

    // Run 1: prime, then hold off until credit
    i_start = 1'b1; cyc(1); i_start = 1'b0;
    chk("busy_in_prime", 32'(o_busy), 32'd1);
    for (int l = 0; l < PL; l++) send_line(l);
    chk("line_after_prime", 32'(o_line_cnt), 32'd4);
    bus.s_data_valid = 1'b1;
    bus.s_data       = 8'hEE;
    repeat (4) begin
      @(negedge axi_clk);
      chk("wait_ready_low", 32'(bus.s_data_ready), 32'd0);
      chk("wait_valid_low", 32'(bus.m_data_valid), 32'd0);
    end
    @(posedge axi_clk); #1;
    bus.s_data_valid = 1'b0;

    // Line 5 with a 3-cycle upstream stall after pixel 2
    pulse_intr();
    send_line(4, 0, 2);
    repeat (3) begin
      @(negedge axi_clk);
      chk("stall_valid_low", 32'(bus.m_data_valid), 32'd0);
      @(posedge axi_clk); #1;
    end
    send_line(4, 3, W - 1);
    chk("line_after_stall", 32'(o_line_cnt), 32'd5);
    pulse_intr();
    send_line(5);
    chk("line_after_img", 32'(o_line_cnt), 32'd6);

    // Padding: two credits -> 16 zero beats
    repeat (2 * W) sb.push_back(8'h00);
    pulse_intr();
    @(negedge axi_clk);
    chk("pad_ready_low", 32'(bus.s_data_ready), 32'd0);
    chk("pad_valid_high", 32'(bus.m_data_valid), 32'd1);
    @(posedge axi_clk); #1;
    cyc(2);
    pulse_intr();
    wait_drain();
    chk("line_after_pad", 32'(o_line_cnt), 32'd8);
    chk("busy_in_drain", 32'(o_busy), 32'd1);

    // 48 result beats; done the cycle after the 48th
    i_out_valid = 1'b1;
    cyc(47);
    chk("done_before_48", 32'(o_done), 32'd0);
    cyc(1);
    i_out_valid = 1'b0;
    @(negedge axi_clk);
    chk("done_after_48", 32'(o_done), 32'd1);
    chk("busy_after_48", 32'(o_busy), 32'd0);
    @(posedge axi_clk); #1;

    // Run 2: re-run from DONE; two credits during prime, results finish before drain
    i_start = 1'b1; cyc(1); i_start = 1'b0;
    chk("rerun_line_clr", 32'(o_line_cnt), 32'd0);
    fork
      begin i_out_valid = 1'b1; cyc(OT); i_out_valid = 1'b0; end
    join_none
    fork
      begin for (int l = 0; l < PL; l++) send_line(l); end
      begin cyc(5); pulse_intr(); cyc(5); pulse_intr(); end
    join
    chk("rerun_line_prime", 32'(o_line_cnt), 32'd4);
    t0 = $time;
    send_line(4);
    send_line(5);
    chk("b2b_no_wait", 32'(($time - t0) / 10 <= 18), 32'd1);
    chk("credit_zero", 32'(dut.r_credit), 32'd0);
    chk("rerun_line_img", 32'(o_line_cnt), 32'd6);
    repeat (2 * W) sb.push_back(8'h00);
    pulse_intr();
    cyc(2);
    pulse_intr();
    wait_drain();
    chk("rerun_line_pad", 32'(o_line_cnt), 32'd8);
    wait_done();
    chk("rerun_busy", 32'(o_busy), 32'd0);

    // Run 3: reset at pixel 3 of line 5 with one credit banked
    i_start = 1'b1; cyc(1); i_start = 1'b0;
    for (int l = 0; l < PL; l++) send_line(l);
    pulse_intr();
    pulse_intr();
    send_line(4, 0, 2);
    bus.s_data_valid = 1'b1;
    bus.s_data       = 8'h43;
    axi_reset_n      = 1'b0;
    @(posedge axi_clk); #1;
    @(negedge axi_clk);
    chk("mid_rst_m_valid", 32'(bus.m_data_valid), 32'd0);
    chk("mid_rst_m_data",  32'(bus.m_data), 32'd0);
    chk("mid_rst_ready",   32'(bus.s_data_ready), 32'd0);
    chk("mid_rst_busy",    32'(o_busy), 32'd0);
    chk("mid_rst_done",    32'(o_done), 32'd0);
    chk("mid_rst_line",    32'(o_line_cnt), 32'd0);
    chk("mid_rst_state",   32'(dut.r_state), 32'(ST_IDLE));
    chk("mid_rst_credit",  32'(dut.r_credit), 32'd0);
    @(posedge axi_clk); #1;
    bus.s_data_valid = 1'b0;
    axi_reset_n      = 1'b1;
    cyc(3);
    chk("idle_after_rst", 32'(o_busy), 32'd0);
    chk("nothing_pending", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_feed_ctrl.md
CONV_FEED_CTRL -- requirements
Module: conv_feed_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 512: pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 360: lines per image.
REQ-003 Parameter PRIME_LINES, default 4: lines sent before the first interrupt is honoured.
REQ-004 Parameter PAD_LINES, default 2: zero lines appended after the image.
REQ-005 Parameter OUT_TOTAL, default 512*360: result beats expected from the conv/maxpool core.
REQ-006 axi_clk  in  1  single clock; all logic on rising edge.
REQ-007 axi_reset_n  in  1  synchronous, active-low reset.
REQ-008 i_start  in  1  one-cycle pulse to begin an image.
REQ-009 s_data_valid / s_data / s_data_ready  in/in/out  1/8/1  upstream pixel stream.
REQ-010 m_data_valid / m_data  out/out  1/8  pixel stream to conv core i_data_valid/i_data.
REQ-011 i_intr  in  1  conv core line-buffer-free interrupt (level).
REQ-012 i_out_valid  in  1  conv core o_data_valid, counted for completion.
REQ-013 o_busy / o_done  out/out  1/1  image in progress / image complete (level).
REQ-014 o_line_cnt  out  9  lines (image plus pad) fully sent.

Function
REQ-015 States SHALL be IDLE, PRIME, WAIT_CREDIT, LINE, PAD_WAIT, PAD, DRAIN, DONE.
REQ-016 IDLE->PRIME on i_start; i_start in any other state except DONE SHALL be ignored.
REQ-017 PRIME SHALL forward PRIME_LINES*IMG_WIDTH pixels, then go to WAIT_CREDIT.
REQ-018 In PRIME/LINE: s_data_ready=1, m_data_valid=s_data_valid, m_data=s_data, combinational, zero latency.
REQ-019 Column counter SHALL advance only on s_data_valid&s_data_ready and hold on upstream stall.
REQ-020 Rising edge of i_intr (registered compare) SHALL increment a 3-bit credit counter, saturating at 7.
REQ-021 WAIT_CREDIT->LINE when credit>0, consuming one credit; edge plus consume in the same cycle SHALL leave credit unchanged.
REQ-022 LINE SHALL forward IMG_WIDTH pixels, then go to WAIT_CREDIT, or to PAD_WAIT after line IMG_HEIGHT.
REQ-023 Credits arriving during PRIME or LINE SHALL be retained.
REQ-024 PAD_WAIT->PAD on credit>0 (consumed); PAD SHALL drive m_data_valid=1, m_data=0 for IMG_WIDTH cycles; s_data_ready=0.
REQ-025 After PAD_LINES pad lines -> DRAIN; outside PRIME/LINE/PAD, m_data_valid=0 and s_data_ready=0.
REQ-026 An 18-bit output counter SHALL count i_out_valid beats from PRIME entry through DRAIN.
REQ-027 DRAIN->DONE when the counter reaches OUT_TOTAL, including a final beat arriving in a pad state.
REQ-028 DONE: o_done=1, o_busy=0; i_start clears all counters, goes to PRIME.
REQ-029 o_busy=1 in PRIME through DRAIN.
REQ-030 o_line_cnt SHALL increment on the last pixel of each line; it SHALL wrap never (max IMG_HEIGHT+PAD_LINES).

Reset
REQ-031 axi_reset_n=0 at a clock edge SHALL force IDLE and clear column, line, credit, and output counters and the intr history register.
REQ-032 Outputs during and after reset: m_data_valid=0, m_data=0, s_data_ready=0, o_busy=0, o_done=0, o_line_cnt=0.
REQ-033 Reset mid-line SHALL abandon the line; no partial state survives.

Structure
REQ-034 Package conv_ctrl_pkg SHALL hold the state enum and default geometry constants (512, 360, 4, 2).
REQ-035 One sub-module feed_line_cnt (column plus line counter with last-pixel and last-line flags) SHALL be instantiated.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, PRIME_LINES=4, PAD_LINES=2, OUT_TOTAL=48)
REQ-036 Start, continuous valid -> exactly 32 m_data_valid beats, then s_data_ready=0 until the first i_intr rise.
REQ-037 Two i_intr pulses during PRIME -> lines 5 and 6 sent back-to-back with no credit wait; credit returns to 0.
REQ-038 s_data_valid low 3 cycles mid-line -> m_data_valid low 3 cycles, line still 8 beats, o_line_cnt +1 at the end.
REQ-039 After line 6, two i_intr rises -> 16 beats m_data=0, m_data_valid=1; o_line_cnt=8.
REQ-040 48 i_out_valid beats -> o_done=1 and o_busy=0 the cycle after the 48th beat; i_start re-runs the image identically.
REQ-041 Reset asserted at pixel 3 of line 5 -> next cycle all outputs zero, state IDLE, credit=0.
